// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// mdu_pkg : funct codes, ALU-control funct constants and MDU state encoding
// Rev 1.0
// ============================================================================
package mdu_pkg;

  // Multiply/divide unit funct codes
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // ALU-control funct codes shared with the integer datapath
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_sign_fix.sv
`default_nettype none
// ============================================================================
// mdu_sign_fix : conditional two's-complement negate (abs when neg_i = sign)
// Rev 1.0
// ============================================================================
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule : mdu_sign_fix
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : iterative HI/LO multiply/divide unit (shift-add / restoring)
// Rev 1.0
// ============================================================================
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic               signed_op;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign signed_op = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign neg_a     = signed_op & op_a[WIDTH-1];
  assign neg_b     = signed_op & op_b[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH))   u_abs_a    (.val_i(op_a),                 .neg_i(neg_a),     .res_o(abs_a));
  mdu_sign_fix #(.W(WIDTH))   u_abs_b    (.val_i(op_b),                 .neg_i(neg_b),     .res_o(abs_b));
  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val_i({acc_hi_q, acc_lo_q}), .neg_i(neg_res_q), .res_o(prod_fix));
  mdu_sign_fix #(.W(WIDTH))   u_fix_quot (.val_i(acc_lo_q),             .neg_i(neg_res_q), .res_o(quot_fix));
  mdu_sign_fix #(.W(WIDTH))   u_fix_rem  (.val_i(acc_hi_q),             .neg_i(neg_rem_q), .res_o(rem_fix));

  // Multiply: acc_lo holds the shrinking multiplier, acc_hi the partial sum.
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_lo_q[WIDTH-1:1]};

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  // The difference always fits WIDTH bits whenever div_ge is set.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_sub   = div_shift[WIDTH-1:0] - opb_q;

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      MDU_IDLE: begin
        if (start && !flush) begin
          unique case (funct)
            FUNCT_MTHI: hi_d = op_a;
            FUNCT_MTLO: lo_d = op_a;
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
              state_d   = MDU_CALC;
              cnt_d     = '0;
              acc_hi_d  = '0;
              is_div_d  = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
              acc_lo_d  = is_div_d ? abs_a : abs_b;
              opb_d     = is_div_d ? abs_b : abs_a;
              neg_res_d = neg_a ^ neg_b;
              neg_rem_d = neg_a;
              div0_d    = (op_b == '0);
            end
            default: ;
          endcase
        end
      end
      MDU_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          {acc_hi_d, acc_lo_d} = mul_next;
        end
        if (cnt_q == CNT_LAST) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        state_d = MDU_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = MDU_IDLE;
    endcase

    if (flush && busy) begin
      state_d = MDU_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : randomized self-checking bench against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_mult_div_unit;

  localparam int         WIDTH = 32;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic             clk = 1'b0;
  logic             reset, start, flush;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a, op_b;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {hi, lo} after the operation, from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    longint      sa, sb, p;
    logic [63:0] up;
    int          q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT:  begin p = sa * sb; return p; end
      F_MULTU: begin up = {32'b0, a} * {32'b0, b}; return up; end
      F_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      F_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      F_MTHI:  return {a, l};
      F_MTLO:  return {h, a};
      default: return {h, l};
    endcase
  endfunction

  // Presents one start in the current cycle and follows it to completion.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    exp   = model(f, a, b, m_hi, m_lo);
    start = 1'b1; funct = f; op_a = a; op_b = b;
    step();
    start = 1'b0; funct = 6'($urandom); op_a = $urandom; op_b = $urandom;
    check_val("done_clr_after_start", {63'b0, done}, 64'd0);
    if (f == F_MTHI || f == F_MTLO) begin
      check_val("mt_busy", {63'b0, busy}, 64'd0);
      check_val("mt_hilo", {hi, lo}, exp);
    end else begin
      check_val("busy_at_T", {63'b0, busy}, 64'd1);
      for (int k = 1; k <= WIDTH; k++) begin
        step();
        check_val("busy_calc", {63'b0, busy}, 64'd1);
        check_val("done_early", {63'b0, done}, 64'd0);
      end
      check_val("hilo_held", {hi, lo}, {m_hi, m_lo});
      step();
      check_val("done_pulse", {63'b0, done}, 64'd1);
      check_val("busy_end", {63'b0, busy}, 64'd0);
      check_val("result", {hi, lo}, exp);
    end
    {m_hi, m_lo} = exp;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] fset [6];
    fset = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct = '0; op_a = '0; op_b = '0;
    m_hi = '0; m_lo = '0;
    step(); step();
    reset = 1'b0;
    check_val("reset_busy", {63'b0, busy}, 64'd0);
    check_val("reset_done", {63'b0, done}, 64'd0);
    check_val("reset_hilo", {hi, lo}, 64'd0);

    // Directed cases
    do_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    step();
    check_val("done_one_cycle", {63'b0, done}, 64'd0);
    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(F_DIV, -32'sd7, 32'd2);              // accepted in the done cycle
    do_op(F_DIVU, 32'd7, 32'd0);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd0);

    // Unsupported funct is ignored
    start = 1'b1; funct = 6'b100000; op_a = 32'h5555_5555;
    step();
    start = 1'b0;
    check_val("bad_funct_busy", {63'b0, busy}, 64'd0);
    check_val("bad_funct_hilo", {hi, lo}, {m_hi, m_lo});

    // MTHI, then MULT flushed ten edges after acceptance; a stray start mid-op is ignored
    do_op(F_MTHI, 32'h1234_5678, 32'd0);
    start = 1'b1; funct = F_MULT; op_a = 32'd3; op_b = 32'd5;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) begin start = 1'b1; funct = F_MTLO; op_a = 32'hDEAD_BEEF; end
      step();
      start = 1'b0;
    end
    check_val("start_while_busy", {hi, lo}, {m_hi, m_lo});
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("flush_busy", {63'b0, busy}, 64'd0);
    check_val("flush_done", {63'b0, done}, 64'd0);
    check_val("flush_hi", {32'b0, hi}, {32'b0, 32'h1234_5678});
    for (int k = 0; k < WIDTH + 4; k++) begin
      step();
      check_val("no_done_after_flush", {63'b0, done}, 64'd0);
    end
    flush = 1'b1; start = 1'b1; funct = F_MTHI; op_a = 32'hABCD_0000;
    step();
    flush = 1'b0; start = 1'b0;
    check_val("flush_beats_mthi", {hi, lo}, {m_hi, m_lo});
    check_val("flush_beats_busy", {63'b0, busy}, 64'd0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      do_op(fset[$urandom_range(0, 5)], rand_word(), rand_word());
      if ($urandom_range(0, 2) == 0) step();
    end

    // Reset in the middle of a divide
    start = 1'b1; funct = F_DIV; op_a = 32'd100; op_b = 32'd7;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("midreset_busy", {63'b0, busy}, 64'd0);
    check_val("midreset_done", {63'b0, done}, 64'd0);
    check_val("midreset_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      step();
      check_val("no_done_after_reset", {63'b0, done}, 64'd0);
    end
    do_op(F_DIVU, 32'd100, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_mult_div_unit
`default_nettype wire
